// File: rtl/pattern_sequencer.sv
// Purpose: two-level pattern timing generator (OSF phases per sample, Len_q samples per frame), one-shot or continuous.
// Latency: Start accepted at edge N -> Busy after N; first Sample_Stb is OSF enabled cycles later; strobes are combinational.
// Backpressure: EN low freezes all counters and suppresses strobes; Abort returns to IDLE at the next edge.
// Optional frame counter: define PATTERN_SEQ_FRAME_CNT_EN to build the Frame_Cnt register (otherwise tied to 0).
module pattern_sequencer #(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  parameter int FRAME_W = 16,
  localparam int SW = ($clog2(SAMPLES) > 1) ? $clog2(SAMPLES) : 1,
  localparam int PW = ($clog2(OSF) > 1) ? $clog2(OSF) : 1,
  localparam int LW = $clog2(SAMPLES) + 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               EN,
  input  logic               Start,
  input  logic               Abort,
  input  logic               Mode,
  input  logic [LW-1:0]      Len,
  output logic               Busy,
  output logic               Done,
  output logic [PW-1:0]      Phase,
  output logic [SW-1:0]      Sample_Idx,
  output logic               Sample_Stb,
  output logic               Frame_Done,
  output logic [FRAME_W-1:0] Frame_Cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PW-1:0] PHASE_MAX = PW'(OSF - 1);
  localparam logic [LW-1:0] SAMPLES_L = LW'(SAMPLES);

  state_t        state, state_nxt;
  logic [LW-1:0] len_q;
  logic          mode_q;
  logic [PW-1:0] phase_q;
  logic [SW-1:0] idx_q;
  logic          start_acc;
  logic          phase_last;
  logic          sample_last;
  logic          stb;
  logic          frame_end;

  // idx_q is one bit narrower than len_q, so zero-extend before comparing against Len_q-1
  assign phase_last  = (phase_q == PHASE_MAX);
  assign sample_last = ({1'b0, idx_q} == (len_q - LW'(1)));

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and strobes; Abort overrides everything, including a same-cycle Start
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    stb       = 1'b0;
    frame_end = 1'b0;
    if (Abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            start_acc = 1'b1;
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (EN && phase_last) begin
            stb = 1'b1;
            if (sample_last) begin
              frame_end = 1'b1;
              if (!mode_q) begin
                state_nxt = S_DONE;
              end
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame parameters and phase/sample counters; out-of-range lengths fall back to the full table
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      len_q   <= '0;
      mode_q  <= 1'b0;
      phase_q <= '0;
      idx_q   <= '0;
    end else if (Abort) begin
      phase_q <= '0;
      idx_q   <= '0;
    end else if (start_acc) begin
      len_q   <= ((Len == '0) || (Len > SAMPLES_L)) ? SAMPLES_L : Len;
      mode_q  <= Mode;
      phase_q <= '0;
      idx_q   <= '0;
    end else if ((state == S_RUN) && EN) begin
      if (phase_last) begin
        phase_q <= '0;
        idx_q   <= sample_last ? '0 : idx_q + SW'(1);
      end else begin
        phase_q <= phase_q + PW'(1);
      end
    end
  end

`ifdef PATTERN_SEQ_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q;

  // Completed-frame counter, restarted by each accepted Start and untouched by Abort
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt_q <= '0;
    end else if (start_acc) begin
      frame_cnt_q <= '0;
    end else if (frame_end) begin
      frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
    end
  end

  assign Frame_Cnt = frame_cnt_q;
`else
  assign Frame_Cnt = '0;
`endif

  assign Busy       = (state == S_RUN);
  assign Done       = (state == S_DONE);
  assign Phase      = phase_q;
  assign Sample_Idx = idx_q;
  assign Sample_Stb = stb;
  assign Frame_Done = frame_end;

endmodule

// File: tb/tb_pattern_sequencer.sv
`timescale 1ns/1ps
module tb_pattern_sequencer;
  localparam int SAMPLES = 8;
  localparam int OSF     = 4;
  localparam int FRAME_W = 16;
  localparam int SW      = 3;
  localparam int PW      = 2;
  localparam int LW      = 4;

  logic               Clk   = 1'b0;
  logic               Reset = 1'b1;
  logic               EN    = 1'b0;
  logic               Start = 1'b0;
  logic               Abort = 1'b0;
  logic               Mode  = 1'b0;
  logic [LW-1:0]      Len   = '0;
  logic               Busy, Done, Sample_Stb, Frame_Done;
  logic [PW-1:0]      Phase;
  logic [SW-1:0]      Sample_Idx;
  logic [FRAME_W-1:0] Frame_Cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 Clk = ~Clk;

  pattern_sequencer #(.SAMPLES(SAMPLES), .OSF(OSF), .FRAME_W(FRAME_W)) dut (
    .Clk(Clk), .Reset(Reset), .EN(EN), .Start(Start), .Abort(Abort), .Mode(Mode), .Len(Len),
    .Busy(Busy), .Done(Done), .Phase(Phase), .Sample_Idx(Sample_Idx),
    .Sample_Stb(Sample_Stb), .Frame_Done(Frame_Done), .Frame_Cnt(Frame_Cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected Frame_Cnt value for a given number of completed frames
  function automatic int fc_exp(int frames);
`ifdef PATTERN_SEQ_FRAME_CNT_EN
    return frames % (1 << FRAME_W);
`else
    return 0 * frames;
`endif
  endfunction

  // Model: a frame is Len*OSF enabled ticks; m_t counts ticks consumed in the current frame
  bit m_run, m_done, m_mode;
  int m_len, m_t, m_fcnt;

  function automatic int eff_len(int l);
    return (l == 0 || l > SAMPLES) ? SAMPLES : l;
  endfunction
  function automatic bit m_stb();
    return m_run && EN && !Abort && ((m_t % OSF) == OSF - 1);
  endfunction
  function automatic bit m_fd();
    return m_stb() && (m_t == m_len * OSF - 1);
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_run <= 0; m_done <= 0; m_mode <= 0; m_len <= 0; m_t <= 0; m_fcnt <= 0;
    end else if (Abort) begin
      m_run <= 0; m_done <= 0; m_t <= 0;
    end else if (!m_run && Start) begin
      m_len <= eff_len(int'(Len)); m_mode <= Mode; m_t <= 0; m_fcnt <= 0;
      m_run <= 1; m_done <= 0;
    end else if (m_run && EN) begin
      if (m_fd()) begin
        m_fcnt <= m_fcnt + 1;
        m_t    <= 0;
        if (!m_mode) begin m_run <= 0; m_done <= 1; end
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge Clk) begin
    if (chk_on) begin
      check("busy", Busy, m_run);
      check("done", Done, m_done);
      check("phase", Phase, m_t % OSF);
      check("sample_idx", Sample_Idx, m_t / OSF);
      check("sample_stb", Sample_Stb, m_stb());
      check("frame_done", Frame_Done, m_fd());
      check("frame_cnt", Frame_Cnt, fc_exp(m_fcnt));
    end
  end

  task automatic start_frame(input int len, input bit mode);
    Start = 1'b1; Len = LW'(len); Mode = mode;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge Clk); #1; end
  endtask

  // Starts a frame and returns the cycle (1 = first RUN cycle) carrying Frame_Done, or -1
  task automatic run_frame(input int len, input bit mode, output int fd_k);
    start_frame(len, mode);
    fd_k = -1;
    for (int k = 1; k <= 100 && fd_k < 0; k++) begin
      @(negedge Clk);
      if (Frame_Done) fd_k = k;
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    int stb_n, fd_k, fd_idx, fd_n, done16;
    int fd_at[3];
    int idx_at[3];
    int ph_at[2];

    // Reset state
    #1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_phase", Phase, 0);
    check("rst_idx", Sample_Idx, 0);
    check("rst_stb", Sample_Stb, 0);
    check("rst_fd", Frame_Done, 0);
    check("rst_fcnt", Frame_Cnt, 0);
    #11 Reset = 1'b0;
    chk_on = 1'b1;
    EN = 1'b1;
    @(posedge Clk); #1;

    // One-shot, Len=8: strobe every 4 cycles, Frame_Done on cycle 32; Len/Mode changes mid-run ignored
    start_frame(8, 0);
    Len = 4'd1; Mode = 1'b1;
    stb_n = 0; fd_k = -1; fd_idx = -1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge Clk);
      if (Sample_Stb) stb_n++;
      if (Frame_Done) begin fd_k = k; fd_idx = Sample_Idx; end
      @(posedge Clk); #1;
    end
    check("t1_stb_count", stb_n, 8);
    check("t1_fd_cycle", fd_k, 32);
    check("t1_fd_idx", fd_idx, 7);
    @(negedge Clk);
    check("t1_done", Done, 1);
    check("t1_busy", Busy, 0);
    @(posedge Clk); #1;

    // Continuous, Len=3, restarted from DONE: Frame_Done at 12, 24, 36
    start_frame(3, 1);
    fd_n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (Frame_Done) begin
        if (fd_n < 3) fd_at[fd_n] = k;
        fd_n++;
      end
      if (k == 5)  idx_at[0] = Sample_Idx;
      if (k == 9)  idx_at[1] = Sample_Idx;
      if (k == 13) idx_at[2] = Sample_Idx;
      @(posedge Clk); #1;
    end
    check("t2_fd_count", fd_n, 3);
    if (fd_n >= 3) begin
      check("t2_fd0", fd_at[0], 12);
      check("t2_fd1", fd_at[1], 24);
      check("t2_fd2", fd_at[2], 36);
    end
    check("t2_idx_k5", idx_at[0], 1);
    check("t2_idx_k9", idx_at[1], 2);
    check("t2_idx_k13", idx_at[2], 0);
    // Start while running is ignored: counters keep going, Frame_Cnt keeps its value
    Start = 1'b1; Len = 4'd5; Mode = 1'b0;
    @(negedge Clk);
    check("t2_fcnt", Frame_Cnt, fc_exp(3));
    check("t2_phase_k41", Phase, 0);
    @(posedge Clk); #1;
    Start = 1'b0;
    @(negedge Clk);
    check("t2_ign_phase", Phase, 1);
    check("t2_ign_busy", Busy, 1);
    check("t2_ign_fcnt", Frame_Cnt, fc_exp(3));
    @(posedge Clk); #1;
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;

    // Out-of-range lengths run full 8-sample frames (20 does not fit the 4-bit Len; 9 and 15 are used)
    run_frame(0, 0, fd_k);
    check("t3_len0", fd_k, 32);
    run_frame(9, 0, fd_k);
    check("t3_len9", fd_k, 32);
    run_frame(15, 0, fd_k);
    check("t3_len15", fd_k, 32);

    // EN toggling 1,0 with Len=2: Frame_Done on cycle 15, Done on cycle 16
    start_frame(2, 0);
    stb_n = 0; fd_k = -1; done16 = -1;
    for (int k = 1; k <= 16; k++) begin
      EN = (k % 2 == 1);
      @(negedge Clk);
      if (Sample_Stb) stb_n++;
      if (Frame_Done) fd_k = k;
      if (k == 4) ph_at[0] = Phase;
      if (k == 5) ph_at[1] = Phase;
      if (k == 16) done16 = Done;
      @(posedge Clk); #1;
    end
    EN = 1'b1;
    check("t4_stb_count", stb_n, 2);
    check("t4_fd_cycle", fd_k, 15);
    check("t4_done_k16", done16, 1);
    check("t4_phase_k4", ph_at[0], 2);
    check("t4_phase_hold_k5", ph_at[1], 2);

    // Abort at Phase=2, Sample_Idx=5 (cycle 23)
    start_frame(8, 0);
    step(22);
    Abort = 1'b1;
    @(negedge Clk);
    check("t5_pre_phase", Phase, 2);
    check("t5_pre_idx", Sample_Idx, 5);
    check("t5_stb", Sample_Stb, 0);
    @(posedge Clk); #1;
    Abort = 1'b0;
    @(negedge Clk);
    check("t5_busy", Busy, 0);
    check("t5_done", Done, 0);
    check("t5_phase", Phase, 0);
    check("t5_idx", Sample_Idx, 0);
    @(posedge Clk); #1;
    // Start and Abort together stay in IDLE
    Start = 1'b1; Abort = 1'b1; Len = 4'd4;
    @(posedge Clk); #1;
    Start = 1'b0; Abort = 1'b0;
    @(negedge Clk);
    check("t5_start_abort_busy", Busy, 0);
    @(posedge Clk); #1;
    // Abort on a would-be Frame_Done cycle: no strobes, Frame_Cnt holds at 1
    start_frame(2, 1);
    step(15);
    Abort = 1'b1;
    @(negedge Clk);
    check("t5b_stb", Sample_Stb, 0);
    check("t5b_fd", Frame_Done, 0);
    @(posedge Clk); #1;
    Abort = 1'b0;
    @(negedge Clk);
    check("t5b_busy", Busy, 0);
    check("t5b_fcnt", Frame_Cnt, fc_exp(1));
    @(posedge Clk); #1;

    // Asynchronous Reset mid-frame clears outputs before the next edge; no restart without Start
    start_frame(8, 0);
    step(10);
    #2 Reset = 1'b1;
    #1;
    check("t6_busy", Busy, 0);
    check("t6_phase", Phase, 0);
    check("t6_idx", Sample_Idx, 0);
    check("t6_stb", Sample_Stb, 0);
    check("t6_fd", Frame_Done, 0);
    check("t6_done", Done, 0);
    check("t6_fcnt", Frame_Cnt, 0);
    #3 Reset = 1'b0;
    step(5);
    @(negedge Clk);
    check("t6_idle_busy", Busy, 0);
    check("t6_idle_phase", Phase, 0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
